// File: rtl/mdu_pkg.sv
// Shared opcode encoding, default latencies and op classification for the MDU issue path.
// Latency: n/a (types and pure functions). Backpressure: n/a.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MSUB  = 4'd9
    } mdu_op_e;

    localparam int unsigned MDU_MULT_LAT_DEF = 5;
    localparam int unsigned MDU_DIV_LAT_DEF  = 10;

    function automatic logic is_long(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
               (op == OP_DIVU) || (op == OP_MSUB);
    endfunction

    function automatic logic is_access(input logic [3:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// Loadable 4-bit down-counter with zero flag; counts out MDU operation latency.
// Latency: load/decrement visible the cycle after the edge. Backpressure: none, saturates at 0.
module mdu_lat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue sequencer: one-cycle start, latency count-out, HI/LO commit strobe, E-stage stall.
// Latency: start comb on accept, hilo_we LAT cycles later. Backpressure: stall while busy.
// Optional MDU_DIV0_FAST_EN adds a div0 input that shortens divide-by-zero to one cycle.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = MDU_MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = MDU_DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_op,
    input  logic       flush,
    output logic       mdu_start,
    output logic [3:0] mdu_op,
    output logic       hilo_we,
    output logic [1:0] move_we,
    output logic       busy,
    output logic       stall
`ifdef MDU_DIV0_FAST_EN
    ,
    input  logic       div0
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       run;
    logic       cls_any;
    logic       req;
    logic       accept;
    logic       cnt_zero;
    logic [3:0] lat_m1;

    assign run     = (state_q == ST_RUN);
    assign cls_any = is_long(req_op) || is_access(req_op);
    assign req     = req_valid && !flush && cls_any;
    assign accept  = !run && req && is_long(req_op);

    always_comb begin
        lat_m1 = is_div(req_op) ? 4'(DIV_LAT - 1) : 4'(MULT_LAT - 1);
`ifdef MDU_DIV0_FAST_EN
        if (is_div(req_op) && div0) begin
            lat_m1 = 4'd0;
        end
`endif
    end

    always_comb begin
        move_we = 2'b00;
        if (!run && req) begin
            if (req_op == OP_MTHI) begin
                move_we = 2'b10;
            end else if (req_op == OP_MTLO) begin
                move_we = 2'b01;
            end
        end
    end

    // Flush is ignored here: an in-flight op still blocks younger MDU instructions.
    assign stall     = run && req_valid && cls_any;
    assign mdu_start = accept;
    assign hilo_we   = run && cnt_zero;
    assign busy      = run;
    assign mdu_op    = op_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        if (accept) begin
            state_d = ST_RUN;
            op_d    = req_op;
        end else if (hilo_we) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    mdu_lat_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (lat_m1),
        .dec      (run),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Table-driven directed bench for mdu_issue_ctrl with default latencies (mult 5, div 10).
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_op;
    logic       flush;
    logic       div0;
    logic       mdu_start;
    logic [3:0] mdu_op;
    logic       hilo_we;
    logic [1:0] move_we;
    logic       busy;
    logic       stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .flush     (flush),
        .mdu_start (mdu_start),
        .mdu_op    (mdu_op),
        .hilo_we   (hilo_we),
        .move_we   (move_we),
        .busy      (busy),
        .stall     (stall)
`ifdef MDU_DIV0_FAST_EN
        ,
        .div0      (div0)
`endif
    );

    typedef struct {
        bit         chk;
        logic       rst;
        logic       vld;
        logic [3:0] op;
        logic       fl;
        logic       d0;
        logic       e_start;
        logic       e_stall;
        logic       e_hilo;
        logic       e_busy;
        logic [1:0] e_move;
        logic [3:0] e_opq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit chk, logic rst, logic vld, logic [3:0] op, logic fl,
                                logic d0, logic st, logic sl, logic hw, logic bz,
                                logic [1:0] mv, logic [3:0] opq);
        vec_t v;
        v.chk = chk; v.rst = rst; v.vld = vld; v.op = op; v.fl = fl; v.d0 = d0;
        v.e_start = st; v.e_stall = sl; v.e_hilo = hw; v.e_busy = bz;
        v.e_move = mv; v.e_opq = opq;
        return v;
    endfunction

    task automatic add(input vec_t v, input int n);
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic add_reset();
        add(mk(0, 1, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 2'b00, OP_NONE), 1);
    endtask

    // Idle cycle with no request: only the registered opcode is interesting.
    task automatic add_idle(input logic [3:0] opq, input int n);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 2'b00, opq), n);
    endtask

    task automatic cmp(input string nm, input int row, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    initial begin
        // A: reset state, then a single mult (LAT 5).
        add_reset();
        add_idle(OP_NONE, 1);
        add(mk(1, 0, 1, OP_MULT, 0, 0, 1, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 1, 2'b00, OP_MULT), 4);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 1, 2'b00, OP_MULT), 1);
        add_idle(OP_MULT, 1);

        // B: div then mflo stalled until the commit, proceeds the cycle after.
        add_reset();
        add(mk(1, 0, 1, OP_DIV, 0, 0, 1, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 1, OP_MFLO, 0, 0, 0, 1, 0, 1, 2'b00, OP_DIV), 9);
        add(mk(1, 0, 1, OP_MFLO, 0, 0, 0, 1, 1, 1, 2'b00, OP_DIV), 1);
        add(mk(1, 0, 1, OP_MFLO, 0, 0, 0, 0, 0, 0, 2'b00, OP_DIV), 1);

        // C: mult then back-to-back divu; divu accepted at c6, commits at c16.
        add_reset();
        add(mk(1, 0, 1, OP_MULT, 0, 0, 1, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 1, OP_DIVU, 0, 0, 0, 1, 0, 1, 2'b00, OP_MULT), 4);
        add(mk(1, 0, 1, OP_DIVU, 0, 0, 0, 1, 1, 1, 2'b00, OP_MULT), 1);
        add(mk(1, 0, 1, OP_DIVU, 0, 0, 1, 0, 0, 0, 2'b00, OP_MULT), 1);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 1, 2'b00, OP_DIVU), 9);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 1, 2'b00, OP_DIVU), 1);
        add_idle(OP_DIVU, 1);

        // D: ACCESS ops and flush in IDLE, undefined opcode, flushed mult.
        add_reset();
        add(mk(1, 0, 1, OP_MTHI, 1, 0, 0, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 1, OP_MTHI, 0, 0, 0, 0, 0, 0, 2'b10, OP_NONE), 1);
        add(mk(1, 0, 1, OP_MTLO, 0, 0, 0, 0, 0, 0, 2'b01, OP_NONE), 1);
        add(mk(1, 0, 1, OP_MTLO, 1, 0, 0, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 1, OP_MFHI, 0, 0, 0, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 0, OP_MTHI, 0, 0, 0, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 1, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 1, OP_MULT, 1, 0, 0, 0, 0, 0, 2'b00, OP_NONE), 1);
        add_idle(OP_NONE, 1);

        // E: reset at c3 of a div aborts it; mult accepted at c4, div never commits.
        add_reset();
        add(mk(1, 0, 1, OP_DIV, 0, 0, 1, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 1, 2'b00, OP_DIV), 2);
        add(mk(1, 1, 0, OP_NONE, 0, 0, 0, 0, 0, 1, 2'b00, OP_DIV), 1);
        add(mk(1, 0, 1, OP_MULT, 0, 0, 1, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 1, 2'b00, OP_MULT), 4);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 1, 2'b00, OP_MULT), 1);
        add_idle(OP_MULT, 2);

        // F: flush while RUN neither cancels the op nor lifts the stall.
        add_reset();
        add(mk(1, 0, 1, OP_MSUB, 0, 0, 1, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 1, OP_MTHI, 1, 0, 0, 1, 0, 1, 2'b00, OP_MSUB), 4);
        add(mk(1, 0, 1, OP_MTHI, 1, 0, 0, 1, 1, 1, 2'b00, OP_MSUB), 1);
        add(mk(1, 0, 1, OP_MTHI, 0, 0, 0, 0, 0, 0, 2'b10, OP_MSUB), 1);

`ifdef MDU_DIV0_FAST_EN
        // G: divide by zero takes one cycle.
        add_reset();
        add(mk(1, 0, 1, OP_DIV, 0, 1, 1, 0, 0, 0, 2'b00, OP_NONE), 1);
        add(mk(1, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 1, 2'b00, OP_DIV), 1);
        add_idle(OP_DIV, 1);
`endif

        reset = 1'b1; req_valid = 1'b0; req_op = OP_NONE; flush = 1'b0; div0 = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < tbl.size(); r++) begin
            reset     = tbl[r].rst;
            req_valid = tbl[r].vld;
            req_op    = tbl[r].op;
            flush     = tbl[r].fl;
            div0      = tbl[r].d0;
            #3;
            if (tbl[r].chk) begin
                cmp("mdu_start", r, {3'b0, mdu_start}, {3'b0, tbl[r].e_start});
                cmp("stall",     r, {3'b0, stall},     {3'b0, tbl[r].e_stall});
                cmp("hilo_we",   r, {3'b0, hilo_we},   {3'b0, tbl[r].e_hilo});
                cmp("busy",      r, {3'b0, busy},      {3'b0, tbl[r].e_busy});
                cmp("move_we",   r, {2'b0, move_we},   {2'b0, tbl[r].e_move});
                cmp("mdu_op",    r, mdu_op,            tbl[r].e_opq);
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Sequencing controller for the multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Decodes the E-stage MDU request and issues a one-cycle start to the arithmetic core.
- Counts out the operation latency and generates the HI/LO commit strobe.
- Drives the pipeline stall for every MDU-class instruction that arrives while the unit is busy.

Parameters:
- MULT_LAT, 5: cycles from accept to commit for mult/multu/msub; legal range 1..15.
- DIV_LAT, 10: cycles from accept to commit for div/divu; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  E-stage instruction is valid (not a bubble).
- req_op  in  4  E-stage MDU opcode (package encoding).
- flush  in  1  E stage is being killed this cycle (exception/interrupt).
- mdu_start  out  1  one-cycle start pulse to the arithmetic core.
- mdu_op  out  4  registered opcode of the in-flight operation.
- hilo_we  out  1  one-cycle strobe; core writes its result to HI/LO this cycle.
- move_we  out  2  bit1 = write HI, bit0 = write LO, from rs (mthi/mtlo); combinational.
- busy  out  1  operation in flight (state RUN).
- stall  out  1  freeze F/D/E and insert a bubble into M; combinational.

Behaviour:
- Op classes:
  - LONG = mult, multu, div, divu, msub.
  - ACCESS = mfhi, mflo, mthi, mtlo.
  - NONE = all other encodings.
- Qualified request: req = req_valid & ~flush & op != NONE.
- Two states:
  - IDLE: cnt = 0, busy = 0.
  - RUN: busy = 1.
- IDLE, req LONG:
  - mdu_start = 1 combinationally; stall = 0, so the instruction proceeds.
  - Next edge: state <- RUN, mdu_op <- req_op, cnt <- LAT-1, where LAT is MULT_LAT or DIV_LAT.
- IDLE, req ACCESS:
  - stall = 0.
  - move_we = 2'b10 for mthi, 2'b01 for mtlo, 0 otherwise.
- RUN:
  - stall = 1 whenever req_valid & op != NONE, regardless of flush.
  - mdu_start = 0, move_we = 0.
  - cnt decrements each cycle.
  - When cnt == 0: hilo_we = 1 that cycle, and next edge state <- IDLE.
- Back-to-back ops: a LONG op arriving on the hilo_we cycle stalls that cycle. It is accepted the following cycle.
  - Issue spacing is therefore LAT+1 cycles.
  - Stalled mfhi/mflo see the committed value.
- LAT = 1: RUN lasts exactly one cycle, and hilo_we is asserted in that cycle.
- flush:
  - In IDLE it suppresses start and move_we.
  - In RUN it does not cancel: the in-flight op was architecturally issued and commits normally.
- reset, including mid-operation:
  - Next edge: state IDLE, cnt 0, mdu_op NONE.
  - All outputs are 0 after the edge; hilo_we is never asserted for the aborted op.
- Undefined opcodes are treated as NONE: no stall, no pulses.

Optional Feature:
- Macro: MDU_DIV0_FAST_EN.
- Defined: a div/divu accepted with divisor-zero flag input div0 (1-bit port present only under the macro) = 1 uses a latency of 1.
  - HI/LO results are whatever the core produces; the MIPS result is unpredictable.
- Undefined: no div0 port; divide latency is always DIV_LAT.

Decomposition:
- Shared package mdu_pkg holds:
  - opcode encoding: NONE=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8, msub=9;
  - default latency constants;
  - is_long/is_access classification functions.
- One natural sub-module, mdu_lat_counter: loadable 4-bit down-counter with a zero flag.

Test Plan:
- Reset, then mult issued at cycle 0: mdu_start=1 at c0, busy c1-c5, hilo_we at c5, busy=0 at c6.
- div at c0, mflo at c1: stall=1 c1-c10, hilo_we c10, mflo proceeds c11 with stall=0.
- mult at c0, divu presented c1: stall through c5, divu accepted c6 (mdu_start=1), its hilo_we at c16.
- mthi with flush=1 in IDLE: move_we=0, mdu_start=0; same with flush=0: move_we=2'b10, stall=0.
- reset asserted at c3 of a div: busy=0 and cnt=0 at c4, no hilo_we ever, next mult accepted at c4.
- MDU_DIV0_FAST_EN defined, div with div0=1 at c0: hilo_we at c0+1, busy only in c1.
